// File: rtl/traffic_controller_n.sv
// Purpose: N-approach round-robin intersection controller with emergency preemption and pedestrian WALK.
// Latency: outputs decode registered state only; an input sampled at edge t shows effect from t+1.
// Backpressure: none; requests are level/pulse inputs, pedestrian requests latch until served.
//
// Ports:
//   clk, rst           - clock and synchronous active-high reset
//   emergency_req[N]   - level emergency request per approach (lowest index wins)
//   ped_req[N]         - pedestrian push-button per approach (pulse or level)
//   red/yellow/green   - lamp outputs per approach (exactly one high per approach)
//   walk[N], buzzer    - pedestrian WALK per approach, buzzer = OR of walk
//   emergency          - high while preemption is in progress
//   emergency_timer    - remaining hold count during EM_HOLD, 0 otherwise
//   active_idx         - approach currently owning the phase
module traffic_controller_n #(
    parameter int N_APPROACH = 4,
    parameter int GREEN_T    = 8,
    parameter int YELLOW_T   = 2,
    parameter int ALLRED_T   = 1,
    parameter int WALK_T     = 5,
    parameter int EMERG_HOLD = 6,
    parameter int TW         = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_APPROACH-1:0]         emergency_req,
    input  logic [N_APPROACH-1:0]         ped_req,
    output logic [N_APPROACH-1:0]         red,
    output logic [N_APPROACH-1:0]         yellow,
    output logic [N_APPROACH-1:0]         green,
    output logic [N_APPROACH-1:0]         walk,
    output logic                          buzzer,
    output logic                          emergency,
    output logic [TW-1:0]                 emergency_timer,
    output logic [$clog2(N_APPROACH)-1:0] active_idx
);
    localparam int IW       = $clog2(N_APPROACH);
    localparam int WALK_EFF = (WALK_T < GREEN_T) ? WALK_T : GREEN_T;
    localparam logic [N_APPROACH-1:0] ONE = N_APPROACH'(1);

    typedef enum logic [2:0] {
        ST_GREEN,
        ST_YELLOW,
        ST_ALL_RED,
        ST_EM_GREEN,
        ST_EM_HOLD
    } state_t;

    state_t                state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  em_q, em_d;
    logic [IW-1:0]         em_idx_q, em_idx_d;
    logic                  post_q, post_d;      // in the yellow/all-red tail that follows an emergency
    logic [TW-1:0]         em_timer_q, em_timer_d;
    logic [N_APPROACH-1:0] pending_q, pending_d;
    logic [N_APPROACH-1:0] walk_q, walk_d;
    logic [TW-1:0]         walk_timer_q, walk_timer_d;

    logic [IW-1:0]         win;
    logic                  req_any;
    logic [IW-1:0]         idx_next_rr;

    // Lowest set index of emergency_req wins.
    always_comb begin
        win = '0;
        for (int i = N_APPROACH - 1; i >= 0; i--) begin
            if (emergency_req[i]) win = IW'(i);
        end
    end

    assign req_any     = |emergency_req;
    assign idx_next_rr = (idx_q == IW'(N_APPROACH - 1)) ? '0 : idx_q + 1'b1;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_ALL_RED;
            timer_q      <= TW'(ALLRED_T - 1);
            idx_q        <= IW'(N_APPROACH - 1);
            em_q         <= 1'b0;
            em_idx_q     <= '0;
            post_q       <= 1'b0;
            em_timer_q   <= '0;
            pending_q    <= '0;
            walk_q       <= '0;
            walk_timer_q <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            idx_q        <= idx_d;
            em_q         <= em_d;
            em_idx_q     <= em_idx_d;
            post_q       <= post_d;
            em_timer_q   <= em_timer_d;
            pending_q    <= pending_d;
            walk_q       <= walk_d;
            walk_timer_q <= walk_timer_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        idx_d        = idx_q;
        em_d         = em_q;
        em_idx_d     = em_idx_q;
        post_d       = post_q;
        em_timer_d   = em_timer_q;
        pending_d    = pending_q | ped_req;
        walk_d       = walk_q;
        walk_timer_d = walk_timer_q;

        if (walk_q != '0) begin
            if (walk_timer_q == '0) walk_d = '0;
            else                    walk_timer_d = walk_timer_q - 1'b1;
        end

        case (state_q)
            ST_GREEN: begin
                if (req_any) begin
                    em_d = 1'b1;
                    if (win == idx_q) begin
                        // Same approach already green: hold it without a yellow.
                        state_d = ST_EM_GREEN;
                        timer_d = '0;
                    end else begin
                        state_d  = ST_YELLOW;
                        timer_d  = TW'(YELLOW_T - 1);
                        em_idx_d = win;
                    end
                end else if (timer_q == '0) begin
                    state_d = ST_YELLOW;
                    timer_d = TW'(YELLOW_T - 1);
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_YELLOW: begin
                if (!post_q && req_any) begin
                    em_d     = 1'b1;
                    em_idx_d = win;
                end
                if (timer_q == '0) begin
                    state_d = ST_ALL_RED;
                    timer_d = TW'(ALLRED_T - 1);
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_ALL_RED: begin
                if (!post_q && req_any) begin
                    em_d     = 1'b1;
                    em_idx_d = win;
                end
                if (timer_q == '0) begin
                    post_d = 1'b0;
                    if (em_d) begin
                        state_d = ST_EM_GREEN;
                        idx_d   = em_idx_d;
                        timer_d = '0;
                    end else begin
                        state_d = ST_GREEN;
                        timer_d = TW'(GREEN_T - 1);
                        // Leaving an emergency, a still-requesting approach is served next.
                        idx_d   = (post_q && req_any) ? win : idx_next_rr;
                        // Grant every pending crossing except the approach going green.
                        walk_d       = pending_q & ~(ONE << idx_d);
                        walk_timer_d = TW'(WALK_EFF - 1);
                        pending_d    = pending_d & ~walk_d;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_EM_GREEN: begin
                if (!emergency_req[idx_q]) begin
                    state_d    = ST_EM_HOLD;
                    em_timer_d = TW'(EMERG_HOLD - 1);
                end
            end
            ST_EM_HOLD: begin
                if (emergency_req[idx_q]) begin
                    state_d    = ST_EM_GREEN;
                    em_timer_d = '0;
                end else if (em_timer_q == '0) begin
                    state_d = ST_YELLOW;
                    timer_d = TW'(YELLOW_T - 1);
                    em_d    = 1'b0;
                    post_d  = 1'b1;
                end else begin
                    em_timer_d = em_timer_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_ALL_RED;
                timer_d = TW'(ALLRED_T - 1);
            end
        endcase

        // Any walk window in progress is abandoned once preemption starts.
        if (em_d) walk_d = '0;
    end

    // Output decode
    always_comb begin
        green  = '0;
        yellow = '0;
        case (state_q)
            ST_GREEN, ST_EM_GREEN, ST_EM_HOLD: green  = ONE << idx_q;
            ST_YELLOW:                         yellow = ONE << idx_q;
            default: ;
        endcase
        red             = ~(green | yellow);
        walk            = em_q ? '0 : walk_q;
        buzzer          = |walk;
        emergency       = em_q;
        emergency_timer = em_timer_q;
        active_idx      = idx_q;
    end

endmodule

// File: tb/tb_traffic_controller_n.sv
// Purpose: directed scoreboard bench for traffic_controller_n (N=4 defaults).
// Latency: one expected output vector per clock, checked at the following falling edge.
// Backpressure: none; the monitor consumes one expectation per cycle.
module tb_traffic_controller_n;
    logic       clk;
    logic       rst;
    logic [3:0] emergency_req;
    logic [3:0] ped_req;
    logic [3:0] red, yellow, green, walk;
    logic       buzzer, emergency;
    logic [3:0] emergency_timer;
    logic [1:0] active_idx;

    traffic_controller_n dut (
        .clk             (clk),
        .rst             (rst),
        .emergency_req   (emergency_req),
        .ped_req         (ped_req),
        .red             (red),
        .yellow          (yellow),
        .green           (green),
        .walk            (walk),
        .buzzer          (buzzer),
        .emergency       (emergency),
        .emergency_timer (emergency_timer),
        .active_idx      (active_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [3:0] g;
        logic [3:0] y;
        logic [3:0] w;
        logic       em;
        logic [3:0] et;
        logic [1:0] idx;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [3:0] oh(input int k);
        logic [3:0] v;
        v = 4'b0001;
        return v << k;
    endfunction

    // Monitor: one expected vector per cycle, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                logic [3:0] r_exp;
                int bad_lamp;
                e = exp_q.pop_front();
                r_exp = ~(e.g | e.y);
                checks++;
                if (red !== r_exp || yellow !== e.y || green !== e.g || walk !== e.w ||
                    buzzer !== (|e.w) || emergency !== e.em || emergency_timer !== e.et ||
                    active_idx !== e.idx) begin
                    errors++;
                    $display("FAIL %s @%0t: got r=%b y=%b g=%b w=%b bz=%b em=%b et=%0d idx=%0d; want r=%b y=%b g=%b w=%b bz=%b em=%b et=%0d idx=%0d",
                             e.tag, $time, red, yellow, green, walk, buzzer, emergency,
                             emergency_timer, active_idx, r_exp, e.y, e.g, e.w, |e.w,
                             e.em, e.et, e.idx);
                end
                bad_lamp = 0;
                for (int i = 0; i < 4; i++) begin
                    if ((int'(red[i]) + int'(yellow[i]) + int'(green[i])) != 1) bad_lamp = 1;
                end
                checks++;
                if (bad_lamp != 0) begin
                    errors++;
                    $display("FAIL lamp_onehot(%s) @%0t: r=%b y=%b g=%b, want one lamp per approach",
                             e.tag, $time, red, yellow, green);
                end
            end
        end
    end

    task automatic tick(input string tag, input logic [3:0] g, input logic [3:0] y,
                        input logic [3:0] w, input logic em, input logic [3:0] et,
                        input logic [1:0] idx);
        exp_t e;
        @(posedge clk);
        e.tag = tag; e.g = g; e.y = y; e.w = w; e.em = em; e.et = et; e.idx = idx;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic green_n(input int k, input int n, input logic [3:0] w);
        for (int i = 0; i < n; i++) tick("green", oh(k), 4'b0, w, 1'b0, 4'd0, 2'(k));
    endtask

    task automatic yellow_n(input int k, input int n, input logic em);
        for (int i = 0; i < n; i++) tick("yellow", 4'b0, oh(k), 4'b0, em, 4'd0, 2'(k));
    endtask

    task automatic allred(input int k, input logic em);
        tick("all_red", 4'b0, 4'b0, 4'b0, em, 4'd0, 2'(k));
    endtask

    task automatic em_green_n(input int k, input int n);
        for (int i = 0; i < n; i++) tick("em_green", oh(k), 4'b0, 4'b0, 1'b1, 4'd0, 2'(k));
    endtask

    task automatic hold(input int k, input int et);
        tick("em_hold", oh(k), 4'b0, 4'b0, 1'b1, 4'(et), 2'(k));
    endtask

    initial begin
        rst = 1'b1;
        emergency_req = 4'b0;
        ped_req = 4'b0;

        // Reset state: all red, last approach owns the phase.
        tick("reset", 4'b0, 4'b0, 4'b0, 1'b0, 4'd0, 2'd3);
        tick("reset", 4'b0, 4'b0, 4'b0, 1'b0, 4'd0, 2'd3);
        rst = 1'b0;

        // Free-run: one full 44-cycle round.
        for (int k = 0; k < 4; k++) begin
            green_n(k, 8, 4'b0);
            yellow_n(k, 2, 1'b0);
            allred(k, 1'b0);
        end

        // Pedestrian: ped[2] during green0 -> walk[2] in green1; ped[1] during green1 stays for green2.
        green_n(0, 1, 4'b0);
        ped_req = 4'b0100;
        green_n(0, 1, 4'b0);
        ped_req = 4'b0;
        green_n(0, 6, 4'b0);
        yellow_n(0, 2, 1'b0);
        allred(0, 1'b0);
        green_n(1, 5, 4'b0100);
        green_n(1, 1, 4'b0);
        ped_req = 4'b0010;
        green_n(1, 1, 4'b0);
        ped_req = 4'b0;
        green_n(1, 1, 4'b0);
        yellow_n(1, 2, 1'b0);
        allred(1, 1'b0);
        green_n(2, 5, 4'b0010);
        green_n(2, 3, 4'b0);
        yellow_n(2, 2, 1'b0);
        allred(2, 1'b0);
        green_n(3, 8, 4'b0);       // pending[2] already cleared: no walk here
        yellow_n(3, 2, 1'b0);
        allred(3, 1'b0);

        // Preempt other approach: emergency[3] for 10 cycles from green0 cycle 3.
        green_n(0, 3, 4'b0);
        emergency_req = 4'b1000;
        yellow_n(0, 2, 1'b1);
        allred(0, 1'b1);
        em_green_n(3, 7);
        emergency_req = 4'b0;
        for (int t = 5; t >= 0; t--) hold(3, t);
        yellow_n(3, 2, 1'b0);
        allred(3, 1'b0);
        green_n(0, 8, 4'b0);
        yellow_n(0, 2, 1'b0);
        allred(0, 1'b0);

        // Preempt current approach with priority; ped[0] in the same cycle stays pending.
        green_n(1, 2, 4'b0);
        emergency_req = 4'b0110;
        ped_req = 4'b0001;
        em_green_n(1, 1);
        ped_req = 4'b0;
        em_green_n(1, 3);
        emergency_req = 4'b0100;   // request [2] ignored during hold
        for (int t = 5; t >= 0; t--) hold(1, t);
        yellow_n(1, 2, 1'b0);
        allred(1, 1'b0);
        tick("post_green2", oh(2), 4'b0, 4'b0001, 1'b0, 4'd0, 2'd2);
        em_green_n(2, 1);

        // Re-assert during hold returns to emergency green.
        emergency_req = 4'b0;
        hold(2, 5);
        hold(2, 4);
        hold(2, 3);
        emergency_req = 4'b0100;
        em_green_n(2, 2);
        emergency_req = 4'b0;
        hold(2, 5);
        hold(2, 4);

        // Reset mid-emergency.
        rst = 1'b1;
        tick("reset_mid_em", 4'b0, 4'b0, 4'b0, 1'b0, 4'd0, 2'd3);
        rst = 1'b0;
        green_n(0, 3, 4'b0);

        // Drain remaining expectations (bounded).
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/traffic_controller_n.md
# traffic_controller_n

Parametrised N-approach intersection controller, successor to the fixed two-approach Traffic_Controller. It cycles green/yellow/all-red phases round-robin over `N_APPROACH` approaches. Per-approach emergency requests preempt the cycle, with lowest index winning. Latched per-approach pedestrian requests drive WALK outputs and a shared buzzer. It sits at the top of the Traffic design and drives the lamp and pedestrian-head outputs directly.

## Interface
Parameters:
- `N_APPROACH`, default 4: number of approaches, legal range 2..8.
- `GREEN_T`, default 8: green phase length in cycles, ≥ 2.
- `YELLOW_T`, default 2: yellow phase length in cycles, ≥ 1.
- `ALLRED_T`, default 1: all-red clearance length in cycles, ≥ 1.
- `WALK_T`, default 5: walk length in cycles. Effective length is min(`WALK_T`, `GREEN_T`).
- `EMERG_HOLD`, default 6: cycles the emergency green is held after the request drops, ≥ 1.
- `TW`, default 4: width of the phase and emergency timers. Must hold every duration − 1.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `emergency_req` input N_APPROACH: level request, one bit per approach.
- `ped_req` input N_APPROACH: pedestrian push-button, one bit per approach. Pulse or level.
- `red` output N_APPROACH: red lamp per approach.
- `yellow` output N_APPROACH: yellow lamp per approach.
- `green` output N_APPROACH: green lamp per approach.
- `walk` output N_APPROACH: pedestrian WALK for crossing approach i.
- `buzzer` output 1: OR of `walk`.
- `emergency` output 1: high while in emergency preemption.
- `emergency_timer` output TW: remaining hold cycles. 0 when not holding.
- `active_idx` output clog2(N_APPROACH): approach currently owning the phase.

## Operation
- States: GREEN, YELLOW, ALL_RED, EM_GREEN, EM_HOLD.
- Phase timer loads duration − 1 on state entry, decrements each cycle, and the state exits when it reaches 0. Each phase therefore lasts exactly its parameter in cycles.
- Normal sequence: GREEN(k) → YELLOW(k) → ALL_RED → GREEN((k+1) mod N).
- Lamps:
  - green[k] is high in GREEN and EM_GREEN/EM_HOLD for approach k.
  - yellow[k] is high in YELLOW for approach k.
  - Every other approach is red.
  - Exactly one of red/yellow/green is high per approach at all times.
- Pedestrian requests:
  - `ped_req[i]` sets pending[i].
  - On entry to GREEN(k), every i ≠ k with pending[i] gets walk[i] for min(WALK_T, GREEN_T) cycles, and its pending bit clears.
  - `ped_req[k]` arriving during GREEN(k) stays pending.
  - `ped_req[i]` arriving mid-green waits for the next GREEN entry.
- Emergency: the winner e is the lowest set index of `emergency_req`, sampled each cycle in GREEN, YELLOW or ALL_RED.
  - In GREEN(e): go to EM_GREEN(e) directly.
  - In GREEN(k≠e): go to YELLOW(k), then ALL_RED, then EM_GREEN(e).
  - In YELLOW or ALL_RED: complete that phase, then go to ALL_RED/EM_GREEN(e).
  - `emergency` is high from the cycle the preemption is taken until EM_HOLD exits.
  - All `walk` outputs are forced low during emergency; pending bits are retained.
- EM_GREEN(e):
  - Stays while `emergency_req[e]` is high.
  - When the request drops, enter EM_HOLD with the timer loaded to EMERG_HOLD − 1.
  - A re-assertion of `emergency_req[e]` in EM_HOLD returns to EM_GREEN.
  - A request from another index j is ignored until EM_HOLD exits.
  - EM_HOLD exits to YELLOW(e), then ALL_RED, then normal green of winner j if still requested, else GREEN((e+1) mod N).
- Simultaneous `emergency_req` and `ped_req` in the same cycle: emergency wins; ped is latched pending.

## Timing
- All outputs are decoded from registered state only; there is no combinational input→output path.
- Reset values (the cycle after `rst` is sampled high):
  - State ALL_RED, phase timer ALLRED_T − 1, `active_idx`=N−1.
  - All `red`=1; `yellow`, `green`, `walk`, `buzzer`, `emergency` all 0; `emergency_timer`=0; pending all 0.
- The first green is approach 0, ALLRED_T cycles after reset release.
- `rst` asserted mid-phase or mid-emergency aborts immediately to the reset state.
- Emergency sampled at edge t with GREEN(k≠e): yellow[k] is visible from t+1.
- Emergency sampled at edge t with GREEN(e): `emergency`=1 from t+1 and green[e] stays continuous.
- `emergency_timer` mirrors the hold countdown: EMERG_HOLD−1 down to 0 during EM_HOLD, and 0 elsewhere.
- `walk` rises in the first GREEN cycle and falls after its window. `buzzer` rises and falls in the same cycles as `walk`.

## Test plan
All scenarios use N_APPROACH=4, GREEN_T=8, YELLOW_T=2, ALLRED_T=1, WALK_T=5, EMERG_HOLD=6.
- **Reset and free-run:** release `rst`, 100 cycles → 1 all-red cycle, then green0×8, yellow0×2, all-red×1, green1…. The round-robin period is 44 cycles. One-hot lamp per approach is checked every cycle.
- **Pedestrian:** pulse ped_req[2] 1 cycle during green0 → walk[2]=buzzer=1 for cycles 1–5 of green1, then low. No walk during green0. pending[2] clears.
- **Preempt other approach:** emergency_req[3] high for 10 cycles at cycle 3 of green0 → yellow0×2, all-red×1, then green3 with emergency=1. After the drop, emergency_timer counts 5→0. Then yellow3, all-red, green0.
- **Preempt current approach plus priority:** emergency_req[1] and [2] rise together during green1 → green1 continuous, emergency=1 next cycle, request [2] ignored. After hold, yellow1, all-red, green2.
- **Re-assert in hold:** drop emergency_req[3] for 3 cycles then raise it again → returns to EM_GREEN, emergency_timer=0, green3 held with no yellow.
- **Reset mid-emergency:** assert `rst` during EM_HOLD → next cycle all red, emergency=0, timer=0, and green0 after 1 cycle.
